time_field_counter: RTL and testbench
=====================================

TIME_FIELD_COUNTER -- requirements
Module: time_field_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 7, the counter width in bits.
REQ-002 SHALL have parameter MIN_VAL, default 0, the lowest count value.
REQ-003 SHALL have parameter MAX_VAL, default 99, the highest count value (MIN_VAL < MAX_VAL < 2^WIDTH).
REQ-004 SHALL have parameter WRAP, default 0, where 0 means saturate at the limits and 1 means wrap between MAX_VAL and MIN_VAL.
REQ-005 SHALL have parameter HOLD_TICKS, default 50, the number of Enable ticks a button is held before auto-repeat starts (≥1).
REQ-006 SHALL have parameter REPEAT_TICKS, default 10, the number of Enable ticks between auto-repeat steps (≥1).
REQ-007 SHALL have port Clock, input, 1 bit, the system clock; all logic is on the rising edge.
REQ-008 SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-009 SHALL have port Enable, input, 1 bit, which qualifies all steps and tick counting.
REQ-010 SHALL have port up, input, 1 bit, the level-sensitive increment button.
REQ-011 SHALL have port down, input, 1 bit, the level-sensitive decrement button.
REQ-012 SHALL have port load, input, 1 bit, the synchronous load strobe.
REQ-013 SHALL have port load_val, input, WIDTH bits, the value to load.
REQ-014 SHALL have port value, output, WIDTH bits, the current count.
REQ-015 SHALL have port bcd_tens, output, 4 bits, the tens digit of value.
REQ-016 SHALL have port bcd_units, output, 4 bits, the units digit of value.
REQ-017 SHALL have port at_max, output, 1 bit, high when value == MAX_VAL.
REQ-018 SHALL have port at_min, output, 1 bit, high when value == MIN_VAL.
REQ-019 SHALL have port carry, output, 1 bit, a one-cycle pulse on each MAX_VAL->MIN_VAL wrap.
REQ-020 SHALL have port borrow, output, 1 bit, a one-cycle pulse on each MIN_VAL->MAX_VAL wrap.

Function
REQ-021 SHALL register up and down every Clock cycle, independent of Enable, for rising-edge detection.
REQ-022 SHALL define the effective request as up XOR down; when up and down are both 1, there is no step and the repeat FSM returns to IDLE.
REQ-023 SHALL implement a repeat FSM with states IDLE, HOLD and REPEAT, plus a tick counter that counts only on cycles where Enable=1.
REQ-024 SHALL, in IDLE, on a request rising edge with Enable=1: step once, latch the direction, clear the tick counter and go to HOLD.
REQ-025 SHALL, in HOLD, after HOLD_TICKS ticks with the request still held: step once, clear the tick counter and go to REPEAT.
REQ-026 SHALL, in REPEAT, step once and clear the tick counter every REPEAT_TICKS ticks while the request is held.
REQ-027 SHALL return to IDLE from HOLD or REPEAT, with no step, on release or on a change of direction; a new press is then required to step again.
REQ-028 SHALL ignore a request rising edge that occurs while Enable=0 (the FSM stays in IDLE).
REQ-029 SHALL make each step visible on value at the same rising edge that detects the step condition (1-cycle latency from the input).
REQ-030 SHALL, on an up-step at MAX_VAL, hold value when WRAP=0, or load MIN_VAL and pulse carry for one cycle when WRAP=1.
REQ-031 SHALL, on a down-step at MIN_VAL, hold value when WRAP=0, or load MAX_VAL and pulse borrow for one cycle when WRAP=1.
REQ-032 SHALL keep carry and borrow at 0 for all non-wrapping steps.
REQ-033 SHALL give load priority over all steps, independent of Enable; value takes load_val clamped to [MIN_VAL, MAX_VAL] on the next edge.
REQ-034 SHALL, on load, force the FSM to IDLE with no carry or borrow, and require a fresh press before stepping again.
REQ-035 SHALL derive bcd_tens and bcd_units combinationally from value, for value ≤ 99.
REQ-036 SHALL drive bcd_tens=bcd_units=4'hF when value > 99.
REQ-037 SHALL derive at_max and at_min combinationally from value.
REQ-038 SHALL keep all arithmetic in WIDTH+1 bits with no unintended overflow; value SHALL never leave [MIN_VAL, MAX_VAL].

Reset
REQ-039 SHALL, while Reset=1 at a rising Clock edge, set value=MIN_VAL, carry=0, borrow=0, FSM=IDLE, tick counter=0 and the edge registers to 0.
REQ-040 SHALL give Reset priority over load and steps, including mid-HOLD or mid-REPEAT; a button still held when Reset is released SHALL NOT step until it is released and pressed again.

Verification
REQ-041 SHALL verify, with defaults: 5 single up presses from reset -> value=5, bcd_tens=0, bcd_units=5; down at 0 -> value stays 0, borrow=0.
REQ-042 SHALL verify, with WRAP=1 and value=99: one up press -> value=0, carry=1 for exactly one cycle; then one down press -> value=99, borrow=1 for exactly one cycle.
REQ-043 SHALL verify, with HOLD_TICKS=3, REPEAT_TICKS=2 and Enable always 1: up held 10 cycles from value 10 -> steps at cycles 1, 4, 6, 8, 10, giving value=15.
REQ-044 SHALL verify: load=1, load_val=120 while up is pressed -> value=99, with no extra step until a new press.
REQ-045 SHALL verify: up=down=1 -> no change; Enable=0 during a press -> no step and ticks frozen.
REQ-046 SHALL verify: Reset asserted mid-REPEAT -> value=MIN_VAL on the next edge and FSM=IDLE.

Source files
------------

// File: rtl/time_field_counter.sv
// -----------------------------------------------------------------------------
// time_field_counter
//   Settable time-field counter (hours/minutes style) driven by up/down
//   buttons. A press steps once. Holding the button for HOLD_TICKS Enable
//   ticks starts auto-repeat, which then steps every REPEAT_TICKS ticks. The
//   value either saturates or wraps at [MIN_VAL, MAX_VAL]. A wrap raises a
//   one-cycle carry (up) or borrow (down) pulse. The current value is also
//   presented as two BCD digits.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Enable     in   tick qualifier for steps and hold/repeat timing
//   up, down   in   level-sensitive increment / decrement buttons
//   load       in   synchronous load strobe; takes priority over steps
//   load_val   in   value to load; clamped into [MIN_VAL, MAX_VAL]
//   value      out  current count
//   bcd_tens   out  tens digit of value (4'hF when value > 99)
//   bcd_units  out  units digit of value (4'hF when value > 99)
//   at_max     out  value == MAX_VAL
//   at_min     out  value == MIN_VAL
//   carry      out  one-cycle pulse on a MAX_VAL -> MIN_VAL wrap
//   borrow     out  one-cycle pulse on a MIN_VAL -> MAX_VAL wrap
// -----------------------------------------------------------------------------
module time_field_counter #(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned MAX_VAL      = 99,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic             at_max,
  output logic             at_min,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MinV    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV    = WIDTH'(MAX_VAL);
  localparam int unsigned      TickMax = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned      TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
  localparam logic [TickW-1:0] HoldLast   = TickW'(HOLD_TICKS - 1);
  localparam logic [TickW-1:0] RepeatLast = TickW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e           r_state, w_state_next;
  logic [TickW-1:0] r_tick, w_tick_next;
  logic             r_dir, w_dir_next;       // 1 = up
  logic             r_up, r_down;
  logic             r_lock, w_lock_next;     // blocks stepping until buttons released
  logic [WIDTH-1:0] r_value, w_value_next;
  logic             r_carry, w_carry_next;
  logic             r_borrow, w_borrow_next;

  logic             w_req, w_req_prev, w_rise, w_step;
  logic [WIDTH:0]   w_inc, w_dec;
  logic [31:0]      w_val32;

  // Repeat FSM and tick counter
  always_comb begin
    w_req        = up ^ down;
    w_req_prev   = r_up ^ r_down;
    w_rise       = w_req & ~w_req_prev & ~r_lock;
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_dir_next   = r_dir;
    w_step       = 1'b0;
    // A button held through reset must be released before it can step.
    w_lock_next  = r_lock & (up | down);

    if (load) begin
      w_state_next = StIdle;
      w_tick_next  = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_rise && Enable) begin
            w_step       = 1'b1;
            w_dir_next   = up;
            w_tick_next  = '0;
            w_state_next = StHold;
          end
        end
        StHold: begin
          if (!w_req || (up != r_dir)) begin
            w_state_next = StIdle;
            w_tick_next  = '0;
          end else if (Enable) begin
            if (r_tick == HoldLast) begin
              w_step       = 1'b1;
              w_tick_next  = '0;
              w_state_next = StRepeat;
            end else begin
              w_tick_next = r_tick + TickW'(1);
            end
          end
        end
        StRepeat: begin
          if (!w_req || (up != r_dir)) begin
            w_state_next = StIdle;
            w_tick_next  = '0;
          end else if (Enable) begin
            if (r_tick == RepeatLast) begin
              w_step      = 1'b1;
              w_tick_next = '0;
            end else begin
              w_tick_next = r_tick + TickW'(1);
            end
          end
        end
        default: begin
          w_state_next = StIdle;
          w_tick_next  = '0;
        end
      endcase
    end
  end

  // Value datapath; increments/decrements are one bit wider so the limit
  // test also catches the arithmetic leaving the representable range.
  always_comb begin
    w_inc         = {1'b0, r_value} + {{WIDTH{1'b0}}, 1'b1};
    w_dec         = {1'b0, r_value} - {{WIDTH{1'b0}}, 1'b1};
    w_value_next  = r_value;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;

    if (load) begin
      if (load_val < MinV) begin
        w_value_next = MinV;
      end else if (load_val > MaxV) begin
        w_value_next = MaxV;
      end else begin
        w_value_next = load_val;
      end
    end else if (w_step) begin
      if (w_dir_next) begin
        if (w_inc > {1'b0, MaxV}) begin
          if (WRAP != 0) begin
            w_value_next = MinV;
            w_carry_next = 1'b1;
          end
        end else begin
          w_value_next = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_dec[WIDTH] || (w_dec < {1'b0, MinV})) begin
          if (WRAP != 0) begin
            w_value_next  = MaxV;
            w_borrow_next = 1'b1;
          end
        end else begin
          w_value_next = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= StIdle;
      r_tick   <= '0;
      r_dir    <= 1'b0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_lock   <= 1'b1;
      r_value  <= MinV;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tick   <= w_tick_next;
      r_dir    <= w_dir_next;
      r_up     <= up;
      r_down   <= down;
      r_lock   <= w_lock_next;
      r_value  <= w_value_next;
      r_carry  <= w_carry_next;
      r_borrow <= w_borrow_next;
    end
  end

  // Outputs
  always_comb begin
    w_val32 = 32'(r_value);
    if (w_val32 > 32'd99) begin
      bcd_tens  = 4'hF;
      bcd_units = 4'hF;
    end else begin
      bcd_tens  = 4'(w_val32 / 32'd10);
      bcd_units = 4'(w_val32 % 32'd10);
    end
  end

  assign value  = r_value;
  assign at_max = (r_value == MaxV);
  assign at_min = (r_value == MinV);
  assign carry  = r_carry;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_time_field_counter.sv
// -----------------------------------------------------------------------------
// tb_time_field_counter
//   Three counter instances share one set of button inputs:
//     dut0  defaults (saturating, HOLD 50, REPEAT 10)
//     dut1  WRAP=1, HOLD_TICKS=3, REPEAT_TICKS=2
//     dut2  MIN_VAL=5, MAX_VAL=120 (clamping and out-of-range BCD)
//   Expected outputs are queued as each cycle's stimulus is driven and
//   compared just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_time_field_counter;

  logic       Clock, Reset, Enable, up, down, load;
  logic [6:0] load_val;

  logic [6:0] val0, val1, val2;
  logic [3:0] tens0, tens1, tens2, units0, units1, units2;
  logic       max0, max1, max2, min0, min1, min2;
  logic       c0, c1, c2, b0, b1, b2;

  time_field_counter u_dut0 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .up(up), .down(down), .load(load),
    .load_val(load_val), .value(val0), .bcd_tens(tens0), .bcd_units(units0),
    .at_max(max0), .at_min(min0), .carry(c0), .borrow(b0)
  );

  time_field_counter #(.WRAP(1), .HOLD_TICKS(3), .REPEAT_TICKS(2)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .up(up), .down(down), .load(load),
    .load_val(load_val), .value(val1), .bcd_tens(tens1), .bcd_units(units1),
    .at_max(max1), .at_min(min1), .carry(c1), .borrow(b1)
  );

  time_field_counter #(.MIN_VAL(5), .MAX_VAL(120)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .up(up), .down(down), .load(load),
    .load_val(load_val), .value(val2), .bcd_tens(tens2), .bcd_units(units2),
    .at_max(max2), .at_min(min2), .carry(c2), .borrow(b2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string tag;
    int    dut;
    int    v;
    int    c;
    int    b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input logic u, input logic d, input logic en, input logic ld,
                       input int lv, input logic rst);
    up       = u;
    down     = d;
    Enable   = en;
    load     = ld;
    load_val = 7'(lv);
    Reset    = rst;
  endtask

  task automatic ex(input string tag, input int dut, input int v, input int c, input int b);
    exp_t e;
    e.tag = tag; e.dut = dut; e.v = v; e.c = c; e.b = b;
    sb.push_back(e);
  endtask

  // dut0 never wraps, so its carry/borrow are always expected low.
  task automatic ex2(input string tag, input int v0, input int v1, input int c1e, input int b1e);
    ex(tag, 0, v0, 0, 0);
    ex(tag, 1, v1, c1e, b1e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] gv, gt, gu, gmx, gmn, gc, gb;
    int          lo, hi, et, eu;
    @(posedge Clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin gv = 32'(val0); gt = 32'(tens0); gu = 32'(units0);
                 gmx = 32'(max0); gmn = 32'(min0); gc = 32'(c0); gb = 32'(b0); end
        1: begin gv = 32'(val1); gt = 32'(tens1); gu = 32'(units1);
                 gmx = 32'(max1); gmn = 32'(min1); gc = 32'(c1); gb = 32'(b1); end
        default: begin gv = 32'(val2); gt = 32'(tens2); gu = 32'(units2);
                 gmx = 32'(max2); gmn = 32'(min2); gc = 32'(c2); gb = 32'(b2); end
      endcase
      lo = (e.dut == 2) ? 5 : 0;
      hi = (e.dut == 2) ? 120 : 99;
      et = (e.v > 99) ? 15 : e.v / 10;
      eu = (e.v > 99) ? 15 : e.v % 10;
      check($sformatf("%s/dut%0d value", e.tag, e.dut), gv, e.v);
      check($sformatf("%s/dut%0d tens", e.tag, e.dut), gt, et);
      check($sformatf("%s/dut%0d units", e.tag, e.dut), gu, eu);
      check($sformatf("%s/dut%0d at_max", e.tag, e.dut), gmx, (e.v == hi) ? 1 : 0);
      check($sformatf("%s/dut%0d at_min", e.tag, e.dut), gmn, (e.v == lo) ? 1 : 0);
      check($sformatf("%s/dut%0d carry", e.tag, e.dut), gc, e.c);
      check($sformatf("%s/dut%0d borrow", e.tag, e.dut), gb, e.b);
    end
  endtask

  int rep_seq[10] = '{11, 11, 11, 12, 12, 13, 13, 14, 14, 15};
  int mid_seq[6]  = '{21, 21, 21, 22, 22, 23};

  initial begin
    drive(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      ex2("reset", 0, 0, 0, 0); ex("reset", 2, 5, 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0); ex2("idle", 0, 0, 0, 0); ex("idle", 2, 5, 0, 0); tick();

    // Single presses from reset
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 1, 0, 0, 0); ex2("up_press", k, k, 0, 0); tick();
      drive(0, 0, 1, 0, 0, 0); ex2("up_rel", k, k, 0, 0); tick();
    end

    // Lower limit: saturate vs wrap
    drive(0, 0, 1, 1, 0, 0);  ex2("load0", 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0);  ex2("down_at_min", 0, 99, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("borrow_end", 0, 99, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("up_at_max", 1, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("carry_end", 1, 0, 0, 0); tick();
    ex2("carry_idle", 1, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0);  ex2("down_wrap2", 0, 99, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("borrow_end2", 0, 99, 0, 0); tick();

    // Upper limit on the saturating instance
    drive(0, 0, 1, 1, 99, 0); ex2("load99", 99, 99, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("up_sat", 99, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("up_sat_rel", 99, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0);  ex2("down_from_max", 98, 99, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("down_rel", 98, 99, 0, 0); tick();

    // Hold and auto-repeat
    drive(0, 0, 1, 1, 10, 0); ex2("load10", 10, 10, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 0, 0); ex2($sformatf("repeat_c%0d", i + 1), 11, rep_seq[i], 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0);  ex2("repeat_rel", 11, 15, 0, 0); tick();

    // Both buttons pressed: no step
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0); ex2("both", 11, 15, 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0);  ex2("both_rel", 11, 15, 0, 0); tick();

    // Press edge while disabled is ignored, even once Enable returns
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0); ex2("dis_press", 11, 15, 0, 0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 0); ex2("dis_then_en", 11, 15, 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0);  ex2("dis_rel", 11, 15, 0, 0); tick();

    // Ticks frozen while Enable=0 during HOLD
    drive(1, 0, 1, 0, 0, 0);  ex2("frz_press", 12, 16, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("frz_t1", 12, 16, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0); ex2("frz_off", 12, 16, 0, 0); tick();
    end
    drive(1, 0, 1, 0, 0, 0);  ex2("frz_t2", 12, 16, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("frz_t3", 12, 17, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("frz_rel", 12, 17, 0, 0); tick();

    // Load during a held press clamps and cancels the press
    drive(1, 0, 1, 0, 0, 0);   ex2("ld_press", 13, 18, 0, 0); tick();
    drive(1, 0, 1, 1, 120, 0); ex2("ld_clamp", 99, 99, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0, 0, 0); ex2("ld_held", 99, 99, 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0);  ex2("ld_rel", 99, 99, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("ld_new_press", 99, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("ld_new_rel", 99, 0, 0, 0); tick();

    // Reset in the middle of REPEAT with the button still held
    drive(0, 0, 1, 1, 20, 0); ex2("load20", 20, 20, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0, 0, 0); ex2($sformatf("mid_c%0d", i + 1), 21, mid_seq[i], 0, 0); tick();
    end
    drive(1, 0, 1, 0, 0, 1);  ex2("mid_reset", 0, 0, 0, 0); ex("mid_reset", 2, 5, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 0, 0); ex2("post_rst_held", 0, 0, 0, 0); tick();
    end
    drive(0, 0, 1, 0, 0, 0);  ex2("post_rst_rel", 0, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);  ex2("post_rst_press", 1, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);  ex2("post_rst_rel2", 1, 1, 0, 0); tick();

    // Non-default range: clamping and out-of-range BCD
    drive(0, 0, 1, 1, 120, 0); ex2("big_ld120", 99, 99, 0, 0); ex("big_ld120", 2, 120, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 0);   ex2("big_ld0", 0, 0, 0, 0); ex("big_ld0", 2, 5, 0, 0); tick();
    drive(0, 0, 1, 1, 100, 0); ex("big_ld100", 2, 100, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0);   ex("big_up", 2, 101, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);   ex("big_up_rel", 2, 101, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0);   ex("big_down", 2, 100, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);   ex("big_down_rel", 2, 100, 0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
